// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// Included by the arbiter top and its priority sub-module.
package mem_port_arbiter_pkg;

    typedef enum logic {IDLE, WAIT_RD} arb_state_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} arb_owner_t;

    localparam int ARB_AW         = 32;
    localparam int ARB_DW         = 32;
    localparam int ARB_STARVE_MAX = 4;

    // Width of a counter that must hold 0..max inclusive (never zero-width).
    function automatic int cnt_width(input int max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_prio.sv
// Winner selection between fetch and data, with a saturating counter of
// consecutive data grants that lets a waiting fetch win once it saturates.
module mem_port_arbiter_arb_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic if_gnt,
    input  logic d_gnt,
    output logic sel_fetch
);

    localparam int CW = cnt_width(STARVE_MAX);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] r_starve_cnt;
    logic          w_saturated;

    assign w_saturated = (r_starve_cnt == CNT_MAX);
    assign sel_fetch   = if_req & (~d_req | w_saturated);

    // Only data grants that actually made a fetch wait count toward starvation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            r_starve_cnt <= '0;
        end else if (d_gnt && !w_saturated) begin
            r_starve_cnt <= r_starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU fetch and load/store accesses onto one single-port memory,
// one outstanding transaction at a time; data has priority over fetch.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = ARB_AW,
    parameter int DW         = ARB_DW,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW/8-1:0] d_we,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_req,
    output logic [AW-1:0]   mem_addr,
    output logic [DW/8-1:0] mem_we,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            err
);

    arb_state_t r_state;
    arb_owner_t r_owner;
    logic       w_sel_fetch;
    logic       w_idle;
    logic       w_accept;

    mem_port_arbiter_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .d_req     (d_req),
        .if_gnt    (if_gnt),
        .d_gnt     (d_gnt),
        .sel_fetch (w_sel_fetch)
    );

    assign w_idle = (r_state == IDLE);

    // Outputs are gated by reset so nothing leaks out during the reset cycle.
    always_comb begin
        mem_req   = !reset && w_idle && (if_req || d_req);
        mem_addr  = '0;
        mem_we    = '0;
        mem_wdata = '0;
        if (mem_req) begin
            if (w_sel_fetch) begin
                mem_addr = if_addr;
            end else begin
                mem_addr  = d_addr;
                mem_we    = d_we;
                mem_wdata = d_wdata;
            end
        end
        w_accept  = mem_req && mem_ready;
        if_gnt    = w_accept && w_sel_fetch;
        d_gnt     = w_accept && !w_sel_fetch;
        if_rvalid = !reset && !w_idle && mem_rvalid && (r_owner == OWN_FETCH);
        d_rvalid  = !reset && !w_idle && mem_rvalid && (r_owner == OWN_DATA);
        err       = !reset && w_idle && mem_rvalid;
        if_rdata  = mem_rdata;
        d_rdata   = mem_rdata;
    end

    // Stores complete on grant, so only reads occupy WAIT_RD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= OWN_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (if_gnt) begin
                        r_state <= WAIT_RD;
                        r_owner <= OWN_FETCH;
                    end else if (d_gnt && (d_we == '0)) begin
                        r_state <= WAIT_RD;
                        r_owner <= OWN_DATA;
                    end
                end
                WAIT_RD: begin
                    if (mem_rvalid) begin
                        r_state <= IDLE;
                        r_owner <= OWN_NONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: memory model with configurable read latency, read-data
// scoreboard, a table of single-cycle arbitration vectors and corner sequences.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_we       (d_we),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] data_for(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    typedef struct {
        logic [1:0]  port;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    // memory model / monitor controls
    int   mem_lat     = 2;
    bit   model_en    = 1'b1;
    bit   force_rv    = 1'b0;
    bit   allow_err   = 1'b0;
    bit   hold_chk    = 1'b0;
    bit   log_en      = 1'b0;
    int   pend        = 0;
    logic [31:0] pend_data = '0;
    int   cyc         = 0;
    byte  glog[$];
    int   gcyc[$];

    initial begin
        bit   hit;
        bit   prev_if_wait;
        bit   prev_d_wait;
        exp_t e;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
        prev_if_wait = 1'b0;
        prev_d_wait  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            hit = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) hit = 1'b1;
            end
            mem_rvalid = hit | force_rv;
            mem_rdata  = hit ? pend_data : (32'hBAD0_0000 | 32'(cyc));
            #1;
            if (if_rvalid || d_rvalid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid", {30'd0, d_rvalid, if_rvalid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rvalid_port", {30'd0, d_rvalid, if_rvalid}, {30'd0, e.port});
                    chk("rdata", if_rvalid ? if_rdata : d_rdata, e.data);
                end
            end
            if (!allow_err) chk("err_quiet", {31'd0, err}, 32'd0);
            if (hold_chk) begin
                if (prev_if_wait && !if_req) chk("if_req_held", 32'd0, 32'd1);
                if (prev_d_wait && !d_req)   chk("d_req_held", 32'd0, 32'd1);
            end
            prev_if_wait = if_req && !if_gnt;
            prev_d_wait  = d_req && !d_gnt;
            if (log_en && (if_gnt || d_gnt)) begin
                glog.push_back(if_gnt ? 8'h46 : 8'h44);
                gcyc.push_back(cyc);
            end
            if (reset) begin
                pend = 0;
                sb.delete();
            end else if (model_en && mem_req && mem_ready && mem_we == 4'h0) begin
                pend      = mem_lat;
                pend_data = data_for(mem_addr);
                e.port    = if_gnt ? 2'b01 : 2'b10;
                e.data    = pend_data;
                sb.push_back(e);
            end
        end
    end

    typedef struct {
        logic        i_if;
        logic        i_d;
        logic [3:0]  we;
        logic        rdy;
        logic        e_req;
        logic        e_ig;
        logic        e_dg;
        logic [3:0]  e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;
    vec_t vt[8];

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        string exp_s;
        vt[0] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0};
        vt[1] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0};
        vt[2] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 32'h80, 32'h11223344};
        vt[3] = '{1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 32'h80, 32'h11223344};
        vt[4] = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 32'h80, 32'h11223344};
        vt[5] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h40, 32'h0};
        vt[6] = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 32'h80, 32'h11223344};
        vt[7] = '{1'b1, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b1, 4'hC, 32'h80, 32'h11223344};

        reset = 1'b1; if_req = 1'b1; if_addr = 32'h10; d_req = 1'b0;
        d_addr = '0; d_we = '0; d_wdata = '0; mem_ready = 1'b1;

        // reset held two cycles with a fetch pending
        repeat (2) begin
            @(negedge clk); #3;
            chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
            chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
            chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        end
        @(negedge clk); reset = 1'b0; #3;
        chk("post_rst_if_gnt", {31'd0, if_gnt}, 32'd1);
        @(negedge clk); if_req = 1'b0;
        idle(4);

        // fetch only, latency 2
        @(negedge clk); if_req = 1'b1; if_addr = 32'h10; #3;
        chk("fetch_gnt", {31'd0, if_gnt}, 32'd1);
        chk("fetch_addr", mem_addr, 32'h10);
        @(negedge clk); if_req = 1'b0; #3;
        chk("fetch_rvalid_early", {31'd0, if_rvalid}, 32'd0);
        @(negedge clk); #3;
        chk("fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("fetch_rdata", if_rdata, 32'h0050_0093);
        idle(3);

        // single-cycle arbitration vectors from IDLE
        if_addr = 32'h40; d_addr = 32'h80; d_wdata = 32'h11223344;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if_req = vt[i].i_if; d_req = vt[i].i_d; d_we = vt[i].we; mem_ready = vt[i].rdy;
            #3;
            chk($sformatf("vec%0d_mem_req", i), {31'd0, mem_req}, {31'd0, vt[i].e_req});
            chk($sformatf("vec%0d_if_gnt", i), {31'd0, if_gnt}, {31'd0, vt[i].e_ig});
            chk($sformatf("vec%0d_d_gnt", i), {31'd0, d_gnt}, {31'd0, vt[i].e_dg});
            chk($sformatf("vec%0d_mem_we", i), {28'd0, mem_we}, {28'd0, vt[i].e_we});
            if (vt[i].e_req) begin
                chk($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].e_addr);
                chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vt[i].e_wdata);
            end
            @(negedge clk);
            if_req = 1'b0; d_req = 1'b0; d_we = '0; mem_ready = 1'b1;
            idle(4);
        end

        // store with a fetch waiting; fetch wins the following cycle
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 4'hF; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        #3;
        chk("store_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("store_if_gnt", {31'd0, if_gnt}, 32'd0);
        chk("store_mem_we", {28'd0, mem_we}, 32'hF);
        chk("store_mem_addr", mem_addr, 32'h200);
        chk("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clk); d_req = 1'b0; d_we = '0; #3;
        chk("store_next_if_gnt", {31'd0, if_gnt}, 32'd1);
        @(negedge clk); if_req = 1'b0;
        idle(4);

        // contention with latency 1: starvation override every fifth grant
        mem_lat = 1; glog.delete(); gcyc.delete();
        @(negedge clk);
        log_en = 1'b1; hold_chk = 1'b1;
        if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_addr = 32'h88; d_we = '0;
        for (int i = 0; i < 200 && glog.size() < 10; i++) @(negedge clk);
        hold_chk = 1'b0; log_en = 1'b0;
        if_req = 1'b0; d_req = 1'b0;
        chk("contention_count", glog.size(), 32'd10);
        exp_s = "DDDDFDDDDF";
        for (int i = 0; i < 10 && i < glog.size(); i++) begin
            chk($sformatf("contention_order%0d", i), {24'd0, glog[i]}, {24'd0, exp_s[i]});
            if (i > 0) chk($sformatf("contention_spacing%0d", i), gcyc[i] - gcyc[i-1], 32'd2);
        end
        idle(4);

        // backpressure on a data read
        mem_lat = 2;
        @(negedge clk);
        hold_chk = 1'b1; mem_ready = 1'b0; d_req = 1'b1; d_addr = 32'h300; d_we = '0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk($sformatf("bp_d_gnt%0d", i), {31'd0, d_gnt}, 32'd0);
            chk($sformatf("bp_mem_addr%0d", i), mem_addr, 32'h300);
            @(negedge clk);
        end
        mem_ready = 1'b1; #3;
        chk("bp_release_d_gnt", {31'd0, d_gnt}, 32'd1);
        @(negedge clk); hold_chk = 1'b0; d_req = 1'b0;
        idle(4);

        // reset during WAIT_RD, then a stale mem_rvalid
        model_en = 1'b0;
        @(negedge clk); if_req = 1'b1; if_addr = 32'h60; #3;
        chk("abort_if_gnt", {31'd0, if_gnt}, 32'd1);
        @(negedge clk); if_req = 1'b0;
        @(negedge clk); reset = 1'b1; #3;
        chk("abort_rst_mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); force_rv = 1'b1; allow_err = 1'b1; #3;
        chk("abort_err", {31'd0, err}, 32'd1);
        chk("abort_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("abort_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        @(negedge clk); force_rv = 1'b0; #3;
        chk("abort_err_pulse", {31'd0, err}, 32'd0);
        allow_err = 1'b0; model_en = 1'b1;
        idle(3);

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
